color_bbox_tracker: RTL and testbench
=====================================

COLOR_BBOX_TRACKER -- requirements
Module: color_bbox_tracker

Interface
REQ-001 Parameter: MIN_PIXELS, 64, minimum per-colour pixel count in a frame for that colour's box to be reported valid.
REQ-002 Parameter: CNT_W, 20, width of the per-colour pixel counters.
REQ-003 clk  input  1  pixel clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 hcount  input  11  current pixel column, 0..1023 in the active region.
REQ-006 vcount  input  10  current pixel row, 0..767 in the active region.
REQ-007 blank  input  1  high outside the active display region.
REQ-008 vsync  input  1  active-low vertical sync from the timing generator.
REQ-009 is_blue / is_green  input  1 each  per-pixel colour-detect flags for the pixel at (hcount, vcount), the same flags that drive the display overlay.
REQ-010 blue_xmin, blue_xmax, green_xmin, green_xmax  output  11 each  latched bounding-box columns.
REQ-011 blue_ymin, blue_ymax, green_ymin, green_ymax  output  10 each  latched bounding-box rows.
REQ-012 blue_cx, green_cx  output  11; blue_cy, green_cy  output  10  latched box centres.
REQ-013 blue_valid, green_valid  output  1 each  latched box is valid.
REQ-014 frame_done  output  1  one-cycle pulse when new results are latched.

Function
REQ-015 Accumulate only when blank=0; when blank=1, ignore is_blue and is_green.
REQ-016 Track each colour independently with its own accumulator set: xmin, xmax, ymin, ymax and count.
REQ-017 A pixel with both flags high updates both colours' accumulators.
REQ-018 Accumulator clear values: xmin=2047, ymin=1023, xmax=0, ymax=0, count=0.
REQ-019 For a qualifying pixel, each min/max updates with an unsigned compare against hcount/vcount; the new value is visible on the next cycle.
REQ-020 Count saturates at 2^CNT_W-1 and never wraps.
REQ-021 Register vsync into vsync_d each cycle; end-of-frame event = vsync_d=1 AND vsync=0 (falling edge), evaluated combinationally.
REQ-022 On the clock edge following an end-of-frame event, for each colour:
  - count >= MIN_PIXELS: latch the box, set valid=1, cx=(xmin+xmax)>>1 and cy=(ymin+ymax)>>1, using 12-/11-bit sums with no overflow.
  - otherwise: drive all box and centre outputs to 0 and valid=0.
REQ-023 On that same edge, pulse frame_done high for exactly one cycle and return all accumulators to their clear values.
REQ-024 If a qualifying pixel coincides with an end-of-frame event, the clear wins and the pixel is discarded.
REQ-025 Outputs hold their values between end-of-frame events; latency from the vsync falling edge to valid outputs is 1 cycle.
REQ-026 vsync held low over many cycles produces exactly one frame_done; a frame with no vsync falling edge produces none.
REQ-027 Implementation is two states: ACCUM (default) and LATCH (one cycle); LATCH returns unconditionally to ACCUM.

Reset
REQ-028 While reset=1: all outputs 0, frame_done=0, valid flags 0, accumulators at clear values, vsync_d=1, state ACCUM.
REQ-029 Reset mid-frame discards partial accumulation; the first frame_done after release reports only pixels seen after release.

Verification
REQ-030 Assert reset -> all outputs 0; release, then vsync falls with no flags seen -> frame_done pulses once, blue_valid=0, green_valid=0.
REQ-031 Blue flagged over x 100..199, y 50..149 (10000 px), then vsync falls -> one cycle later blue box (100,199,50,149), blue_cx=149, blue_cy=99, blue_valid=1, green_valid=0.
REQ-032 63 blue pixels in a frame with MIN_PIXELS=64 -> blue_valid=0 and all blue box outputs 0; the next frame with 64 pixels -> blue_valid=1.
REQ-033 Both flags high at (1023,767) only, with MIN_PIXELS=1 -> both boxes (1023,1023,767,767), cx=1023, cy=767; flags held high during blank are not counted.
REQ-034 Reset pulsed at row 400 after blue pixels in rows 0..399, then blue in rows 500..509 at x=10 -> reported blue box (10,10,500,509).
REQ-035 Qualifying pixel forced on the end-of-frame cycle -> pixel absent from both the latched results and the next frame's results; vsync held low for 100 cycles -> exactly one frame_done.

Source files
------------

// File: rtl/color_bbox_tracker.sv
// color_bbox_tracker
//   Accumulates a bounding box and pixel count for blue and green pixels
//   during each frame's active region. On each falling edge of vsync, it
//   latches the boxes and centres for reporting, then clears the
//   accumulators for the next frame.
//
// Ports
//   clk, reset        : pixel clock, asynchronous active-high reset
//   hcount, vcount    : current pixel column (11 bits) / row (10 bits)
//   blank             : high outside the active region (pixels ignored)
//   vsync             : active-low vertical sync
//   is_blue, is_green : per-pixel colour-detect flags
//   <c>_xmin/xmax/ymin/ymax, <c>_cx/cy, <c>_valid : latched results per colour
//   frame_done        : one-cycle pulse when new results are latched
module color_bbox_tracker #(
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        blank,
    input  logic        vsync,
    input  logic        is_blue,
    input  logic        is_green,
    output logic [10:0] blue_xmin,
    output logic [10:0] blue_xmax,
    output logic [9:0]  blue_ymin,
    output logic [9:0]  blue_ymax,
    output logic [10:0] green_xmin,
    output logic [10:0] green_xmax,
    output logic [9:0]  green_ymin,
    output logic [9:0]  green_ymax,
    output logic [10:0] blue_cx,
    output logic [9:0]  blue_cy,
    output logic [10:0] green_cx,
    output logic [9:0]  green_cy,
    output logic        blue_valid,
    output logic        green_valid,
    output logic        frame_done
);

    typedef enum logic {ACCUM, LATCH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    // Index 0 = blue, 1 = green.
    logic [10:0]      xmin_acc [2];
    logic [10:0]      xmax_acc [2];
    logic [9:0]       ymin_acc [2];
    logic [9:0]       ymax_acc [2];
    logic [CNT_W-1:0] cnt_acc  [2];

    logic [10:0] xmin_q [2];
    logic [10:0] xmax_q [2];
    logic [9:0]  ymin_q [2];
    logic [9:0]  ymax_q [2];
    logic [10:0] cx_q   [2];
    logic [9:0]  cy_q   [2];
    logic [1:0]  valid_q;

    state_t state;
    logic   vsync_d;
    logic   eof;
    logic   take;
    logic [1:0] hit;

    assign eof  = vsync_d & ~vsync;
    assign take = (state == ACCUM) && eof;
    assign hit  = {is_green, is_blue} & {2{~blank}};

    // Midpoints use one extra bit so the sum of two maxima cannot overflow.
    function automatic logic [10:0] mid11(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[11:1];
    endfunction

    function automatic logic [9:0] mid10(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[10:1];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            vsync_d    <= 1'b1;
            frame_done <= 1'b0;
            valid_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                xmin_acc[i] <= 11'd2047;
                xmax_acc[i] <= '0;
                ymin_acc[i] <= 10'd1023;
                ymax_acc[i] <= '0;
                cnt_acc[i]  <= '0;
                xmin_q[i]   <= '0;
                xmax_q[i]   <= '0;
                ymin_q[i]   <= '0;
                ymax_q[i]   <= '0;
                cx_q[i]     <= '0;
                cy_q[i]     <= '0;
            end
        end else begin
            vsync_d <= vsync;

            case (state)
                ACCUM: begin
                    if (eof) begin
                        state      <= LATCH;
                        frame_done <= 1'b1;
                    end
                end
                LATCH: begin
                    state      <= ACCUM;
                    frame_done <= 1'b0;
                end
                default: begin
                    state      <= ACCUM;
                    frame_done <= 1'b0;
                end
            endcase

            for (int i = 0; i < 2; i++) begin
                if (take) begin
                    // Clear takes priority: a pixel on the end-of-frame cycle is dropped.
                    if (cnt_acc[i] >= MIN_CNT) begin
                        valid_q[i] <= 1'b1;
                        xmin_q[i]  <= xmin_acc[i];
                        xmax_q[i]  <= xmax_acc[i];
                        ymin_q[i]  <= ymin_acc[i];
                        ymax_q[i]  <= ymax_acc[i];
                        cx_q[i]    <= mid11(xmin_acc[i], xmax_acc[i]);
                        cy_q[i]    <= mid10(ymin_acc[i], ymax_acc[i]);
                    end else begin
                        valid_q[i] <= 1'b0;
                        xmin_q[i]  <= '0;
                        xmax_q[i]  <= '0;
                        ymin_q[i]  <= '0;
                        ymax_q[i]  <= '0;
                        cx_q[i]    <= '0;
                        cy_q[i]    <= '0;
                    end
                    xmin_acc[i] <= 11'd2047;
                    xmax_acc[i] <= '0;
                    ymin_acc[i] <= 10'd1023;
                    ymax_acc[i] <= '0;
                    cnt_acc[i]  <= '0;
                end else if (hit[i]) begin
                    if (hcount < xmin_acc[i]) xmin_acc[i] <= hcount;
                    if (hcount > xmax_acc[i]) xmax_acc[i] <= hcount;
                    if (vcount < ymin_acc[i]) ymin_acc[i] <= vcount;
                    if (vcount > ymax_acc[i]) ymax_acc[i] <= vcount;
                    if (cnt_acc[i] != CNT_MAX) cnt_acc[i] <= cnt_acc[i] + 1'b1;
                end
            end
        end
    end

    assign blue_xmin   = xmin_q[0];
    assign blue_xmax   = xmax_q[0];
    assign blue_ymin   = ymin_q[0];
    assign blue_ymax   = ymax_q[0];
    assign blue_cx     = cx_q[0];
    assign blue_cy     = cy_q[0];
    assign blue_valid  = valid_q[0];
    assign green_xmin  = xmin_q[1];
    assign green_xmax  = xmax_q[1];
    assign green_ymin  = ymin_q[1];
    assign green_ymax  = ymax_q[1];
    assign green_cx    = cx_q[1];
    assign green_cy    = cy_q[1];
    assign green_valid = valid_q[1];

endmodule

// File: tb/tb_color_bbox_tracker.sv
// Testbench for color_bbox_tracker: directed frames, with a reference model
// that pushes the expected per-colour results into a queue. A negedge monitor
// pops and compares them whenever frame_done pulses.
module tb_color_bbox_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        blank, vsync, is_blue, is_green;
    logic [10:0] blue_xmin, blue_xmax, green_xmin, green_xmax;
    logic [9:0]  blue_ymin, blue_ymax, green_ymin, green_ymax;
    logic [10:0] blue_cx, green_cx;
    logic [9:0]  blue_cy, green_cy;
    logic        blue_valid, green_valid, frame_done;

    color_bbox_tracker dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .blank(blank), .vsync(vsync), .is_blue(is_blue), .is_green(is_green),
        .blue_xmin(blue_xmin), .blue_xmax(blue_xmax),
        .blue_ymin(blue_ymin), .blue_ymax(blue_ymax),
        .green_xmin(green_xmin), .green_xmax(green_xmax),
        .green_ymin(green_ymin), .green_ymax(green_ymax),
        .blue_cx(blue_cx), .blue_cy(blue_cy),
        .green_cx(green_cx), .green_cy(green_cy),
        .blue_valid(blue_valid), .green_valid(green_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic [10:0] cx;
        logic [9:0]  cy;
    } box_t;

    box_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   fd_cnt = 0;

    // Reference accumulators, index 0 = blue, 1 = green.
    int mxmin[2], mxmax[2], mymin[2], mymax[2], mcnt[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mxmin[i] = 2047; mxmax[i] = 0; mymin[i] = 1023; mymax[i] = 0; mcnt[i] = 0;
        end
    endtask

    function automatic box_t model_box(input int i);
        box_t b;
        b = '0;
        if (mcnt[i] >= 64) begin
            b.valid = 1'b1;
            b.xmin  = 11'(mxmin[i]);
            b.xmax  = 11'(mxmax[i]);
            b.ymin  = 10'(mymin[i]);
            b.ymax  = 10'(mymax[i]);
            b.cx    = 11'((mxmin[i] + mxmax[i]) / 2);
            b.cy    = 10'((mymin[i] + mymax[i]) / 2);
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int h, input int v, input logic b, input logic g, input logic bl);
        logic [1:0] f;
        hcount = 11'(h); vcount = 10'(v);
        is_blue = b; is_green = g; blank = bl;
        f = {g, b};
        if (!bl) begin
            for (int i = 0; i < 2; i++) begin
                if (f[i]) begin
                    if (h < mxmin[i]) mxmin[i] = h;
                    if (h > mxmax[i]) mxmax[i] = h;
                    if (v < mymin[i]) mymin[i] = v;
                    if (v > mymax[i]) mymax[i] = v;
                    mcnt[i]++;
                end
            end
        end
        step();
        is_blue = 1'b0; is_green = 1'b0; blank = 1'b0;
    endtask

    // Falling vsync; optionally a flagged pixel on the end-of-frame cycle,
    // which the model drops. vsync stays low for 'hold' cycles.
    task automatic end_frame(input bit inject, input int hold);
        vsync = 1'b1;
        step();
        exp_q.push_back(model_box(0));
        exp_q.push_back(model_box(1));
        model_clear();
        vsync = 1'b0;
        if (inject) begin
            hcount = 11'd500; vcount = 10'd300; blank = 1'b0;
            is_blue = 1'b1; is_green = 1'b1;
        end
        step();
        is_blue = 1'b0; is_green = 1'b0;
        repeat (hold - 1) step();
        vsync = 1'b1;
        step();
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            if (exp_q.size() < 2) begin
                check("unexpected_frame_done", 64'(exp_q.size()), 64'd2);
            end else begin
                box_t eb, eg;
                eb = exp_q.pop_front();
                eg = exp_q.pop_front();
                check("blue_box", {blue_valid, blue_xmin, blue_xmax, blue_ymin, blue_ymax, blue_cx, blue_cy}, eb);
                check("green_box", {green_valid, green_xmin, green_xmax, green_ymin, green_ymax, green_cx, green_cy}, eg);
            end
        end
    end

    initial begin
        int fd_before;
        reset = 1'b1; vsync = 1'b1; blank = 1'b0;
        is_blue = 1'b0; is_green = 1'b0; hcount = '0; vcount = '0;
        model_clear();
        repeat (3) step();
        check("reset_blue", {blue_valid, blue_xmin, blue_xmax, blue_ymin, blue_ymax, blue_cx, blue_cy}, 64'd0);
        check("reset_green", {green_valid, green_xmin, green_xmax, green_ymin, green_ymax, green_cx, green_cy}, 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        reset = 1'b0;
        repeat (2) step();

        // Empty frame.
        fd_before = fd_cnt;
        end_frame(0, 1);
        check("empty_frame_one_pulse", 64'(fd_cnt - fd_before), 64'd1);

        // Blue 100x100 block.
        for (int y = 50; y <= 149; y++)
            for (int x = 100; x <= 199; x++)
                pixel(x, y, 1'b1, 1'b0, 1'b0);
        end_frame(0, 2);

        // 63 pixels (below threshold), then 64 (at threshold).
        for (int i = 0; i < 63; i++) pixel(300 + i, 200, 1'b1, 1'b0, 1'b0);
        end_frame(0, 2);
        for (int i = 0; i < 64; i++) pixel(300 + i, 201, 1'b1, 1'b0, 1'b0);
        end_frame(0, 2);

        // Flags during blank are ignored; both colours at the far corner.
        for (int i = 0; i < 5; i++) pixel(0, 0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) pixel(1023, 767, 1'b1, 1'b1, 1'b0);
        end_frame(0, 2);

        // Reset mid-frame discards earlier accumulation.
        for (int y = 0; y < 400; y++) pixel(10, y, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        model_clear();
        repeat (2) step();
        check("midreset_blue_zero", {blue_valid, blue_xmin, blue_xmax, blue_ymin, blue_ymax, blue_cx, blue_cy}, 64'd0);
        reset = 1'b0;
        step();
        for (int y = 500; y <= 509; y++)
            for (int k = 0; k < 7; k++) pixel(10, y, 1'b1, 1'b0, 1'b0);
        end_frame(0, 2);

        // Green block; pixel injected on end-of-frame; vsync held low 100 cycles.
        for (int y = 30; y <= 31; y++)
            for (int x = 20; x <= 59; x++) pixel(x, y, 1'b0, 1'b1, 1'b0);
        fd_before = fd_cnt;
        end_frame(1, 100);
        check("long_vsync_one_pulse", 64'(fd_cnt - fd_before), 64'd1);

        // Next frame must not contain the injected (500,300) pixel.
        for (int i = 0; i < 64; i++) pixel(600 + i, 400, 1'b1, 1'b0, 1'b0);
        end_frame(0, 2);

        // Pixels with no vsync falling edge: no frame_done.
        fd_before = fd_cnt;
        for (int i = 0; i < 80; i++) pixel(700, 100 + i, 1'b1, 1'b1, 1'b0);
        repeat (20) step();
        check("no_vsync_no_pulse", 64'(fd_cnt - fd_before), 64'd0);

        repeat (5) step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
